// File: rtl/display_scan_controller.sv
// Two-digit common-anode scan controller: synchronises and debounces a 4-bit value, splits it into
// tens/units and time-multiplexes both digits onto one decode bus with blanking gaps between them.
module display_scan_controller #(
  parameter int unsigned REFRESH_CYCLES = 27000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned STABLE_CYCLES  = 270000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          LZ_BLANK       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] binary_code,
  output logic [3:0] digit_code,
  output logic [1:0] anode,
  output logic       frame_tick,
  output logic [3:0] value_accepted
);

  localparam int unsigned PhaseMax = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES
                                                                     : BLANK_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax);
  localparam int unsigned StW      = $clog2(STABLE_CYCLES + 1);

  localparam logic [PhaseW-1:0] RefreshLast = PhaseW'(REFRESH_CYCLES - 1);
  localparam logic [PhaseW-1:0] BlankLast   = PhaseW'(BLANK_CYCLES - 1);
  localparam logic [StW-1:0]    StableLast  = StW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {StUnitsOn, StBlankU, StTensOn, StBlankT} state_e;

  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  function automatic logic [3:0] tens_of(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  cand_q, cand_d;
  logic [StW-1:0]              cnt_q, cnt_d;
  logic [3:0]                  acc_q, acc_d;
  logic [3:0]                  frame_q, frame_d;
  state_e                      state_q, state_d;
  logic [PhaseW-1:0]           phase_q, phase_d;
  logic [3:0]                  digit_q, digit_d;
  logic [1:0]                  anode_q, anode_d;
  logic                        tick_q, tick_d;
  logic [3:0]                  s;
  logic                        phase_last;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = binary_code;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // The sample that loads the candidate counts as the first stable sample, so a value is
  // accepted on the STABLE_CYCLES-th consecutive equal sample.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = '0;
    end else if (cnt_q != StableLast) begin
      cnt_d = cnt_q + StW'(1);
    end
    if (cnt_d == StableLast) begin
      acc_d = s;
    end
  end

  always_comb begin
    phase_last = ((state_q == StUnitsOn) || (state_q == StTensOn)) ? (phase_q == RefreshLast)
                                                                   : (phase_q == BlankLast);
    state_d = state_q;
    phase_d = phase_q + PhaseW'(1);
    frame_d = frame_q;
    digit_d = digit_q;
    anode_d = anode_q;
    tick_d  = 1'b0;
    if (phase_last) begin
      phase_d = '0;
      unique case (state_q)
        StBlankT: begin
          state_d = StUnitsOn;
          frame_d = acc_q;
          digit_d = units_of(acc_q);
          anode_d = 2'b10;
          tick_d  = 1'b1;
        end
        StUnitsOn: begin
          state_d = StBlankU;
          anode_d = 2'b11;
        end
        StBlankU: begin
          state_d = StTensOn;
          digit_d = tens_of(frame_q);
          anode_d = (LZ_BLANK && (tens_of(frame_q) == 4'd0)) ? 2'b11 : 2'b01;
        end
        StTensOn: begin
          state_d = StBlankT;
          anode_d = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      frame_q <= '0;
      state_q <= StBlankT;
      phase_q <= '0;
      digit_q <= '0;
      anode_q <= 2'b11;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
      state_q <= state_d;
      phase_q <= phase_d;
      digit_q <= digit_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  assign digit_code     = digit_q;
  assign anode          = anode_q;
  assign frame_tick     = tick_q;
  assign value_accepted = acc_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomised bench for display_scan_controller: two instances (leading-zero blanking on and off)
// checked every cycle against a timeline model built from frame arithmetic and a sample history.
module tb_display_scan_controller;

  localparam int unsigned R  = 8;
  localparam int unsigned B  = 2;
  localparam int unsigned S  = 4;
  localparam int unsigned SY = 2;
  localparam int unsigned P  = 2 * (R + B);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] binary_code = 4'd0;
  logic [3:0] digit_a, digit_b, acc_a, acc_b;
  logic [1:0] anode_a, anode_b;
  logic       tick_a, tick_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .STABLE_CYCLES(S), .SYNC_STAGES(SY), .LZ_BLANK(1'b1)
  ) u_dut_lz (
    .clk(clk), .rst(rst), .binary_code(binary_code), .digit_code(digit_a), .anode(anode_a),
    .frame_tick(tick_a), .value_accepted(acc_a)
  );

  display_scan_controller #(
    .REFRESH_CYCLES(R), .BLANK_CYCLES(B), .STABLE_CYCLES(S), .SYNC_STAGES(SY), .LZ_BLANK(1'b0)
  ) u_dut_nolz (
    .clk(clk), .rst(rst), .binary_code(binary_code), .digit_code(digit_b), .anode(anode_b),
    .frame_tick(tick_b), .value_accepted(acc_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: bq[n] is the input sampled at the (n+1)-th edge after reset release; k counts edges.
  logic [3:0] bq[$];
  int         k;
  logic [3:0] m_acc;
  logic [3:0] m_frame;

  function automatic logic [3:0] s_at(input int j);
    if (j - int'(SY) >= 1) return bq[j-SY-1];
    return 4'd0;
  endfunction

  function automatic int model_phase();
    if (k < int'(B)) return -1;
    return (k - B) % P;
  endfunction

  task automatic model_reset();
    k = 0;
    bq.delete();
    m_acc   = 4'd0;
    m_frame = 4'd0;
  endtask

  task automatic model_step(input logic [3:0] b);
    bit eq;
    k++;
    bq.push_back(b);
    if (k >= int'(B) && (k - B) % P == 0) m_frame = m_acc;
    eq = 1'b1;
    for (int i = 1; i < int'(S); i++) begin
      if (s_at(k - i) != s_at(k)) eq = 1'b0;
    end
    if (eq) m_acc = s_at(k);
  endtask

  task automatic check_outputs();
    int ph;
    logic [3:0] ed, u, t;
    logic [1:0] ea, eb;
    logic et;
    ph = model_phase();
    u  = (m_frame >= 4'd10) ? m_frame - 4'd10 : m_frame;
    t  = (m_frame >= 4'd10) ? 4'd1 : 4'd0;
    et = 1'b0;
    if (ph < 0) begin
      ed = 4'd0; ea = 2'b11; eb = 2'b11;
    end else if (ph < int'(R)) begin
      ed = u; ea = 2'b10; eb = 2'b10; et = (ph == 0);
    end else if (ph < int'(R + B)) begin
      ed = u; ea = 2'b11; eb = 2'b11;
    end else if (ph < int'(2 * R + B)) begin
      ed = t; eb = 2'b01; ea = (t == 4'd0) ? 2'b11 : 2'b01;
    end else begin
      ed = t; ea = 2'b11; eb = 2'b11;
    end
    check("digit_lz", digit_a, ed);
    check("digit_nolz", digit_b, ed);
    check("anode_lz", anode_a, ea);
    check("anode_nolz", anode_b, eb);
    check("tick_lz", tick_a, et);
    check("tick_nolz", tick_b, et);
    check("acc_lz", acc_a, m_acc);
    check("acc_nolz", acc_b, m_acc);
    check("anode_nz_lz", int'(anode_a == 2'b00), 0);
    check("anode_nz_nolz", int'(anode_b == 2'b00), 0);
    check("digit_le9", int'(digit_a > 4'd9), 0);
  endtask

  task automatic tick(input logic [3:0] b, input logic r);
    @(negedge clk);
    binary_code = b;
    rst = r;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else model_step(b);
    check_outputs();
  endtask

  task automatic run_to_phase(input logic [3:0] b, input int target);
    int n;
    n = 0;
    while (model_phase() != target && n < int'(4 * P)) begin
      tick(b, 1'b0);
      n++;
    end
  endtask

  initial begin
    int v, n;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_outputs();
    repeat (3) tick(4'd0, 1'b1);

    for (int i = 1; i <= 45; i++) begin
      tick(4'd0, 1'b0);
      if (i == 1) check("tick_before_first", tick_a, 0);
      if (i == 2) check("first_tick", tick_a, 1);
      if (i == 22) check("second_tick", tick_a, 1);
    end

    for (int i = 1; i <= 6; i++) begin
      tick(4'd13, 1'b0);
      if (i == 5) check("acc13_early", acc_a, 0);
      if (i == 6) check("acc13_edge6", acc_a, 13);
    end
    run_to_phase(4'd13, 0);
    check("units13", digit_a, 3);
    check("units13_anode", anode_a, 2);
    run_to_phase(4'd13, int'(R + B));
    check("tens13", digit_a, 1);
    check("tens13_anode", anode_a, 1);

    repeat (10) tick(4'd5, 1'b0);
    repeat (2) tick(4'd7, 1'b0);
    repeat (2) tick(4'd5, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(4'd7, 1'b0);
      if (i == 5) check("bounce_hold5", acc_a, 5);
      if (i == 6) check("bounce_acc7", acc_a, 7);
    end
    repeat (40) tick(4'd7, 1'b0);

    run_to_phase(4'd9, int'(R + B));
    run_to_phase(4'd9, int'(R + B));
    check("nolz_tens9_digit", digit_b, 0);
    check("nolz_tens9_anode", anode_b, 1);
    run_to_phase(4'd9, 0);
    check("units9", digit_b, 9);

    repeat (10) tick(4'd4, 1'b0);
    run_to_phase(4'd4, int'(R + B));
    for (int i = 1; i <= 6; i++) tick(4'd12, 1'b0);
    check("acc12_in_tens", acc_a, 12);
    check("tens_unchanged", digit_a, 0);
    run_to_phase(4'd12, 0);
    check("units12", digit_a, 2);
    run_to_phase(4'd12, int'(R + B));
    check("tens12", digit_a, 1);

    repeat (60) begin
      v = $urandom_range(0, 15);
      n = $urandom_range(1, 12);
      repeat (n) tick(v[3:0], 1'b0);
    end

    repeat (10) tick(4'd15, 1'b0);
    run_to_phase(4'd15, int'(R + B + 3));
    check("pre_rst_anode", anode_a, 1);
    #2 rst = 1'b1;
    #1;
    check("async_anode", anode_a, 3);
    check("async_digit", digit_a, 0);
    check("async_acc", acc_a, 0);
    model_reset();
    check_outputs();
    repeat (2) tick(4'd15, 1'b1);
    for (int i = 1; i <= 25; i++) begin
      tick(4'd15, 1'b0);
      if (i == 5) check("refilter_hold", acc_a, 0);
      if (i == 6) check("refilter_acc15", acc_a, 15);
      if (i == 2) check("tick_after_rst", tick_a, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Sequences a shared 7-segment decode path across a two-digit common-anode display.
- Takes the 4-bit binary value produced by the Gray decoder and filters it for stability, since the value comes from asynchronous switches.
- Splits the value into tens and units, then time-multiplexes them onto one digit_code bus with one-hot active-low anode enables.
- Inserts blanking gaps between digits to prevent ghosting. Sits between the Gray decoder output and the display decoder input.

Parameters:
- REFRESH_CYCLES, 27000, clock cycles each digit is lit (1 ms at 27 MHz); must be ≥2.
- BLANK_CYCLES, 16, clock cycles all anodes are off between digits; must be ≥1.
- STABLE_CYCLES, 270000, cycles the synchronized input must stay unchanged before it is accepted; must be ≥1.
- SYNC_STAGES, 2, flip-flop stages per input bit; must be ≥2.
- LZ_BLANK, 1, when 1 the tens digit is not lit if tens==0.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- binary_code  in  4  decoded value 0..15; asynchronous to clk
- digit_code  out  4  value for display decoder (0..9)
- anode  out  2  active-low digit enables; bit0 = units, bit1 = tens
- frame_tick  out  1  one-cycle pulse at the start of each frame
- value_accepted  out  4  current filtered value (debug/status)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All state resets immediately on rst assertion, mid-frame included.
- Reset values:
  - digit_code = 0, anode = 2'b11, frame_tick = 0, value_accepted = 0.
  - Sync chain = 0, candidate = 0, stability count = 0, frame value = 0.
  - State = BLANK_T, phase counter = 0.
- Input path: each bit passes through a SYNC_STAGES flop chain, giving value s.
  - Candidate register: if s != candidate, then candidate <= s and count <= 0.
  - Otherwise, if count < STABLE_CYCLES-1, count increments.
  - Otherwise value_accepted <= candidate.
  - A clean input change becomes visible on value_accepted exactly SYNC_STAGES+STABLE_CYCLES rising edges after the change.
  - Any bounce restarts the count, and value_accepted holds its old value.
- Split: tens = (v ≥ 10) ? 1 : 0; units = (v ≥ 10) ? v−10 : v. Use 4-bit arithmetic; no value above 9 ever appears on digit_code.
- FSM states: UNITS_ON, BLANK_U, TENS_ON, BLANK_T, cycled in that order.
  - The phase counter runs 0..N−1 in each state and resets to 0 on every transition.
  - N = REFRESH_CYCLES for the ON states and BLANK_CYCLES for the blank states.
  - A transition occurs on the edge where counter == N−1.
- BLANK_T → UNITS_ON is the frame boundary:
  - The frame value register latches value_accepted.
  - digit_code <= units of the latched value; anode <= 2'b10.
  - frame_tick = 1 for exactly that first UNITS_ON cycle. All outputs are registered.
- UNITS_ON → BLANK_U: anode <= 2'b11; digit_code holds.
- BLANK_U → TENS_ON: digit_code <= tens of the frame value (same frame, never re-sampled mid-frame).
  - anode <= 2'b01, or 2'b11 if LZ_BLANK==1 and tens==0.
- TENS_ON → BLANK_T: anode <= 2'b11; digit_code holds.
- Both anode bits are never 0 simultaneously.
- Frame period = 2·(REFRESH_CYCLES+BLANK_CYCLES) cycles.
- First frame_tick occurs BLANK_CYCLES cycles after rst deassertion.
- A value_accepted change mid-frame takes effect only at the next frame boundary. If the change lands on the boundary cycle itself, the pre-edge value is latched.

Test Plan:
(bench parameters: REFRESH_CYCLES=8, BLANK_CYCLES=2, STABLE_CYCLES=4, SYNC_STAGES=2, LZ_BLANK=1)
- Reset, then release with binary_code=0:
  - All outputs stay at reset values.
  - frame_tick pulses 2 cycles after release.
  - anode = 10 for 8 cycles, then 11 for 2 cycles, then 11 for the 8-cycle TENS_ON (leading zero blanked), then 11 for 2.
  - Period = 20 cycles.
- binary_code=13 held stable:
  - value_accepted = 13 exactly 6 edges after the change.
  - Next frame: digit_code = 3 with anode = 10, then digit_code = 1 with anode = 01.
- Bounce: binary_code toggles 5→7→5 with 2 cycles between changes, then holds 7 → value_accepted stays 5 until 6 edges after the final change, then becomes 7; digit_code never shows 7 mid-frame.
- binary_code=9, LZ_BLANK=0 → units slot shows 9 on anode 10; tens slot shows 0 on anode 01; anode never equals 00.
- Value changes from 4 to 12 and is accepted during TENS_ON → remainder of the frame unchanged; next frame shows 2 then 1.
- Assert rst during TENS_ON with value 15 → anode = 11 and digit_code = 0 immediately (asynchronous). After release, value_accepted = 0 until re-filtered; frame_tick again occurs 2 cycles after release.
